// File: rtl/id_stage_if.sv
// id_stage_if: bundles the fetch, write-back and execute-facing signals of the
// decode stage.
//   master : drives the fetch/write-back inputs and observes the decode results
//            (fetch/write-back side or testbench).
//   slave  : the decode stage itself.
//   Fetch side     : if_instruction, if_pc in; branch_taken, branch_address out.
//   Write-back     : wb_en, wb_dest, wb_value in.
//   Execute side   : id_pc, exe_cmd, val1, val2, st_value, dest, wb_en_out,
//                    mem_r_en, mem_w_en out.
interface id_stage_if;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] id_pc;
    logic [3:0]  exe_cmd;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_value;
    logic [4:0]  dest;
    logic        wb_en_out;
    logic        mem_r_en;
    logic        mem_w_en;

    modport master (
        output if_instruction, if_pc, wb_en, wb_dest, wb_value,
        input  branch_taken, branch_address, id_pc, exe_cmd, val1, val2,
               st_value, dest, wb_en_out, mem_r_en, mem_w_en
    );

    modport slave (
        input  if_instruction, if_pc, wb_en, wb_dest, wb_value,
        output branch_taken, branch_address, id_pc, exe_cmd, val1, val2,
               st_value, dest, wb_en_out, mem_r_en, mem_w_en
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage. Holds the IF/ID pipeline register and
// the 32x32 register file, decodes the 6-bit-opcode ISA into execute controls
// and operands, and resolves BEZ/BNE/JMP in decode (taken branch redirects
// fetch and squashes the wrong-path instruction).
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : id_stage_if.slave (fetch inputs, write-back port, decode outputs)
// All decode outputs are combinational from IF/ID and the register file.
module id_stage (
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_AND  = 4'd4;
    localparam logic [3:0] CMD_OR   = 4'd5;
    localparam logic [3:0] CMD_NOR  = 4'd6;
    localparam logic [3:0] CMD_XOR  = 4'd7;
    localparam logic [3:0] CMD_SHL  = 4'd8;
    localparam logic [3:0] CMD_SRA  = 4'd9;
    localparam logic [3:0] CMD_SRL  = 4'd10;
    localparam logic [3:0] CMD_NONE = 4'd15;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd3,
        OP_AND  = 6'd5,
        OP_OR   = 6'd6,
        OP_NOR  = 6'd7,
        OP_XOR  = 6'd8,
        OP_SLA  = 6'd9,
        OP_SLL  = 6'd10,
        OP_SRA  = 6'd11,
        OP_SRL  = 6'd12,
        OP_ADDI = 6'd32,
        OP_SUBI = 6'd33,
        OP_LD   = 6'd36,
        OP_ST   = 6'd37,
        OP_BEZ  = 6'd40,
        OP_BNE  = 6'd41,
        OP_JMP  = 6'd42
    } opcode_e;

    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] regs [32];

    logic [5:0]  op;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic [3:0]  cmd;
    logic        we;
    logic        mr;
    logic        mw;
    logic [4:0]  dst;
    logic [31:0] v2;
    logic        taken;

    assign op  = ifid_instr[31:26];
    assign s1  = ifid_instr[25:21];
    assign s2  = ifid_instr[20:16];
    assign rd  = ifid_instr[15:11];
    assign imm = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

    // Register reads: R0 is hard zero; a write-back in flight to the same
    // index is returned in the same cycle (write-through bypass).
    always_comb begin
        rd1 = '0;
        if (s1 != 5'd0) begin
            rd1 = (bus.wb_en && bus.wb_dest == s1) ? bus.wb_value : regs[s1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (s2 != 5'd0) begin
            rd2 = (bus.wb_en && bus.wb_dest == s2) ? bus.wb_value : regs[s2];
        end
    end

    always_comb begin
        cmd   = CMD_NONE;
        we    = 1'b0;
        mr    = 1'b0;
        mw    = 1'b0;
        dst   = rd;
        v2    = rd2;
        taken = 1'b0;
        case (op)
            OP_ADD:  begin cmd = CMD_ADD; we = 1'b1; end
            OP_SUB:  begin cmd = CMD_SUB; we = 1'b1; end
            OP_AND:  begin cmd = CMD_AND; we = 1'b1; end
            OP_OR:   begin cmd = CMD_OR;  we = 1'b1; end
            OP_NOR:  begin cmd = CMD_NOR; we = 1'b1; end
            OP_XOR:  begin cmd = CMD_XOR; we = 1'b1; end
            OP_SLA:  begin cmd = CMD_SHL; we = 1'b1; end
            OP_SLL:  begin cmd = CMD_SHL; we = 1'b1; end
            OP_SRA:  begin cmd = CMD_SRA; we = 1'b1; end
            OP_SRL:  begin cmd = CMD_SRL; we = 1'b1; end
            OP_ADDI: begin cmd = CMD_ADD; we = 1'b1; dst = s2; v2 = imm; end
            OP_SUBI: begin cmd = CMD_SUB; we = 1'b1; dst = s2; v2 = imm; end
            OP_LD:   begin cmd = CMD_ADD; we = 1'b1; mr = 1'b1; dst = s2; v2 = imm; end
            OP_ST:   begin cmd = CMD_ADD; mw = 1'b1; v2 = imm; end
            OP_BEZ:  taken = (rd1 == 32'd0);
            OP_BNE:  taken = (rd1 != rd2);
            OP_JMP:  taken = 1'b1;
            default: ;
        endcase
    end

    assign bus.branch_taken   = taken;
    assign bus.branch_address = ifid_pc + 32'd4 + {imm[29:0], 2'b00};
    assign bus.id_pc          = ifid_pc;
    assign bus.exe_cmd        = cmd;
    assign bus.val1           = rd1;
    assign bus.val2           = v2;
    assign bus.st_value       = rd2;
    assign bus.dest           = we ? dst : 5'd0;
    assign bus.wb_en_out      = we;
    assign bus.mem_r_en       = mr;
    assign bus.mem_w_en       = mw;

    // A taken branch squashes the instruction fetched behind it; the PC is
    // still captured so the bubble carries the flushed address.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr <= '0;
            ifid_pc    <= '0;
        end else begin
            ifid_instr <= taken ? 32'd0 : bus.if_instruction;
            ifid_pc    <= bus.if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (bus.wb_en && bus.wb_dest != 5'd0) begin
            regs[bus.wb_dest] <= bus.wb_value;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage. A behavioural model (register
// array, IF/ID contents, opcode table) predicts every decode output each cycle;
// directed scenarios add literal expectations; randomized traffic follows.
module tb_id_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          taken;
        logic [31:0] target;
        logic [3:0]  cmd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] stv;
        logic [4:0]  dst;
        bit          we;
        bit          mr;
        bit          mw;
        bit          vals_care;
    } exp_t;

    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_valid = 1'b0;
    logic [3:0]  cmd_tab [64];

    initial begin
        foreach (cmd_tab[i]) cmd_tab[i] = 4'd15;
        cmd_tab[1]  = 4'd0;  cmd_tab[3]  = 4'd2;  cmd_tab[5]  = 4'd4;
        cmd_tab[6]  = 4'd5;  cmd_tab[7]  = 4'd6;  cmd_tab[8]  = 4'd7;
        cmd_tab[9]  = 4'd8;  cmd_tab[10] = 4'd8;  cmd_tab[11] = 4'd9;
        cmd_tab[12] = 4'd10; cmd_tab[32] = 4'd0;  cmd_tab[33] = 4'd2;
        cmd_tab[36] = 4'd0;  cmd_tab[37] = 4'd0;
    end

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_en && bus.wb_dest == idx) return bus.wb_value;
        return m_regs[idx];
    endfunction

    function automatic exp_t model_decode();
        exp_t        e;
        int          op;
        logic [31:0] a, b, imm;
        op  = int'(m_instr[31:26]);
        a   = m_read(m_instr[25:21]);
        b   = m_read(m_instr[20:16]);
        imm = {{16{m_instr[15]}}, m_instr[15:0]};
        e = '{taken: 0, target: m_pc + 32'd4 + (imm << 2), cmd: cmd_tab[op],
              v1: a, v2: b, stv: b, dst: 5'd0, we: 0, mr: 0, mw: 0, vals_care: 0};
        if (op inside {1, 3, 5, 6, 7, 8, 9, 10, 11, 12}) begin
            e.we = 1; e.dst = m_instr[15:11]; e.vals_care = 1;
        end else if (op inside {32, 33, 36}) begin
            e.we = 1; e.dst = m_instr[20:16]; e.v2 = imm; e.mr = (op == 36); e.vals_care = 1;
        end else if (op == 37) begin
            e.mw = 1; e.v2 = imm; e.vals_care = 1;
        end else if (op == 40) begin
            e.taken = (a == 32'd0);
        end else if (op == 41) begin
            e.taken = (a != b);
        end else if (op == 42) begin
            e.taken = 1;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_instr = '0;
            m_pc    = '0;
            foreach (m_regs[i]) m_regs[i] = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            e = model_decode();
            if (bus.wb_en && bus.wb_dest != 5'd0) m_regs[bus.wb_dest] = bus.wb_value;
            m_instr = e.taken ? 32'd0 : bus.if_instruction;
            m_pc    = bus.if_pc;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (m_valid) begin
            e = model_decode();
            check("branch_taken",   32'(bus.branch_taken), 32'(e.taken));
            check("branch_address", bus.branch_address, e.target);
            check("id_pc",          bus.id_pc, m_pc);
            check("exe_cmd",        32'(bus.exe_cmd), 32'(e.cmd));
            check("st_value",       bus.st_value, e.stv);
            check("dest",           32'(bus.dest), 32'(e.dst));
            check("wb_en_out",      32'(bus.wb_en_out), 32'(e.we));
            check("mem_r_en",       32'(bus.mem_r_en), 32'(e.mr));
            check("mem_w_en",       32'(bus.mem_w_en), 32'(e.mw));
            if (e.vals_care) begin
                check("val1", bus.val1, e.v1);
                check("val2", bus.val2, e.v2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
        bus.if_instruction = ins;
        bus.if_pc          = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] d, input logic [31:0] v);
        bus.wb_en    = 1'b1;
        bus.wb_dest  = d;
        bus.wb_value = v;
        feed(32'd0, 32'd0);
        bus.wb_en    = 1'b0;
    endtask

    logic [5:0] ops [18] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                             6'd11, 6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42};

    initial begin
        logic [31:0] ins_bne;
        logic [31:0] rpc;
        logic [5:0]  rop;

        bus.if_instruction = '0;
        bus.if_pc          = '0;
        bus.wb_en          = 1'b0;
        bus.wb_dest        = '0;
        bus.wb_value       = '0;
        rst = 1'b1;
        feed(32'd0, 32'd0);
        feed(32'd0, 32'd0);
        rst = 1'b0;

        @(negedge clk);
        check("rst exe_cmd",   32'(bus.exe_cmd), 32'd15);
        check("rst taken",     32'(bus.branch_taken), 32'd0);
        check("rst id_pc",     bus.id_pc, 32'd0);
        check("rst dest",      32'(bus.dest), 32'd0);
        check("rst val1",      bus.val1, 32'd0);
        check("rst val2",      bus.val2, 32'd0);
        check("rst st_value",  bus.st_value, 32'd0);
        check("rst enables",   {29'd0, bus.wb_en_out, bus.mem_r_en, bus.mem_w_en}, 32'd0);

        // ADDI r1,r0,1546 at pc 4
        feed(32'h8001060A, 32'd4);
        @(negedge clk);
        check("addi cmd",  32'(bus.exe_cmd), 32'd0);
        check("addi val1", bus.val1, 32'd0);
        check("addi val2", bus.val2, 32'd1546);
        check("addi dest", 32'(bus.dest), 32'd1);
        check("addi we",   32'(bus.wb_en_out), 32'd1);
        check("addi pc",   bus.id_pc, 32'd4);

        // SUB r2,r0,r3 with r3 written back in the same cycle
        feed({6'd3, 5'd0, 5'd3, 5'd2, 11'd0}, 32'd8);
        bus.wb_en = 1'b1; bus.wb_dest = 5'd3; bus.wb_value = 32'hFFFFF9F6;
        @(negedge clk);
        check("bypass val2", bus.val2, 32'hFFFFF9F6);
        check("sub dest",    32'(bus.dest), 32'd2);
        feed({6'd1, 5'd0, 5'd0, 5'd4, 11'd0}, 32'd12);
        bus.wb_dest = 5'd0; bus.wb_value = 32'd5;
        @(negedge clk);
        check("r0 bypass val1", bus.val1, 32'd0);
        feed({6'd1, 5'd0, 5'd3, 5'd4, 11'd0}, 32'd16);
        bus.wb_en = 1'b0;
        @(negedge clk);
        check("r0 after write", bus.val1, 32'd0);
        check("r3 stored",      bus.val2, 32'hFFFFF9F6);

        // BEZ r9,2 at 0x120
        feed({6'd40, 5'd9, 5'd0, 16'd2}, 32'h120);
        @(negedge clk);
        check("bez taken",  32'(bus.branch_taken), 32'd1);
        check("bez target", bus.branch_address, 32'h12C);
        feed(32'h8001060A, 32'h124);
        @(negedge clk);
        check("flush cmd",   32'(bus.exe_cmd), 32'd15);
        check("flush we",    32'(bus.wb_en_out), 32'd0);
        check("flush pc",    bus.id_pc, 32'h124);
        check("flush taken", 32'(bus.branch_taken), 32'd0);

        // BNE r1,r3,-15
        ins_bne = {6'd41, 5'd1, 5'd3, 16'hFFF1};
        wb(5'd1, 32'd3);
        wb(5'd3, 32'd3);
        feed(ins_bne, 32'h200);
        @(negedge clk);
        check("bne equal", 32'(bus.branch_taken), 32'd0);
        wb(5'd3, 32'd2);
        feed(ins_bne, 32'h200);
        @(negedge clk);
        check("bne taken",  32'(bus.branch_taken), 32'd1);
        check("bne target", bus.branch_address, 32'h1C8);
        feed(32'd0, 32'd0);

        // JMP -1 at 0x180, repeatedly fetched
        feed(32'hA800FFFF, 32'h180);
        @(negedge clk);
        check("jmp taken",  32'(bus.branch_taken), 32'd1);
        check("jmp target", bus.branch_address, 32'h180);
        feed(32'hA800FFFF, 32'h180);
        @(negedge clk);
        check("jmp bubble", 32'(bus.branch_taken), 32'd0);
        check("jmp bubble cmd", 32'(bus.exe_cmd), 32'd15);
        feed(32'hA800FFFF, 32'h180);
        @(negedge clk);
        check("jmp again", 32'(bus.branch_taken), 32'd1);
        feed(32'd0, 32'd0);

        // LD r6,r8,-4
        feed({6'd36, 5'd8, 5'd6, 16'hFFFC}, 32'h300);
        @(negedge clk);
        check("ld val2", bus.val2, 32'hFFFFFFFC);
        check("ld mr",   32'(bus.mem_r_en), 32'd1);
        check("ld dest", 32'(bus.dest), 32'd6);

        // ST r7,r1,20
        wb(5'd7, 32'hFFFFE7D8);
        feed({6'd37, 5'd1, 5'd7, 16'd20}, 32'h304);
        @(negedge clk);
        check("st mw",    32'(bus.mem_w_en), 32'd1);
        check("st value", bus.st_value, 32'hFFFFE7D8);
        check("st we",    32'(bus.wb_en_out), 32'd0);
        check("st dest",  32'(bus.dest), 32'd0);

        // opcode 63
        feed(32'hFC2A8001, 32'h308);
        @(negedge clk);
        check("op63 cmd",  32'(bus.exe_cmd), 32'd15);
        check("op63 flags", {28'd0, bus.branch_taken, bus.wb_en_out, bus.mem_r_en, bus.mem_w_en}, 32'd0);
        check("op63 dest", 32'(bus.dest), 32'd0);

        // randomized traffic, small register range to provoke hazards and equal compares
        rpc = 32'h1000;
        for (int n = 0; n < 1500; n++) begin
            rop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 17)];
            bus.wb_en    = 1'($urandom_range(0, 1));
            bus.wb_dest  = 5'($urandom_range(0, 7));
            bus.wb_value = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            feed({rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)}, rpc);
            rpc = ($urandom_range(0, 15) == 0) ? {$urandom, 2'b00} >> 2 << 2 : rpc + 32'd4;
        end
        bus.wb_en = 1'b0;

        // reset mid-program; a concurrent write-back must be discarded
        bus.wb_en = 1'b1; bus.wb_dest = 5'd5; bus.wb_value = 32'h1234;
        rst = 1'b1;
        feed(32'h8001060A, 32'h44);
        rst = 1'b0;
        bus.wb_en = 1'b0;
        @(negedge clk);
        check("mid rst cmd",  32'(bus.exe_cmd), 32'd15);
        check("mid rst we",   32'(bus.wb_en_out), 32'd0);
        check("mid rst pc",   bus.id_pc, 32'd0);
        feed({6'd1, 5'd5, 5'd7, 5'd4, 11'd0}, 32'h48);
        @(negedge clk);
        check("mid rst r5", bus.val1, 32'd0);
        check("mid rst r7", bus.val2, 32'd0);

        feed(32'd0, 32'd0);
        feed(32'd0, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
